// File: rtl/st_operand_feeder_if.sv
// Bundle of load port, sequence control/config and the three Avalon-ST sources of st_operand_feeder.
// slave = the feeder itself; master = host/DMA loader plus the array-side sinks.
interface st_operand_feeder_if #(
  parameter int LANES   = 32,
  parameter int ELEM_W  = 8,
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 32,
  parameter int REP_W   = 8
);
  localparam int DW = LANES * ELEM_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic               ld_write;
  logic               ld_sel;
  logic [AW-1:0]      ld_addr;
  logic [DW-1:0]      ld_data;
  logic               start;
  logic               abort;
  logic [CW-1:0]      cfg_count;
  logic [REP_W-1:0]   cfg_rep;
  logic [INSTR_W-1:0] cfg_instr;
  logic               busy;
  logic               done;
  logic [INSTR_W-1:0] st_instr_data;
  logic               st_instr_valid;
  logic               st_instr_ready;
  logic [DW-1:0]      st_rows_data;
  logic               st_rows_valid;
  logic               st_rows_ready;
  logic [DW-1:0]      st_cols_data;
  logic               st_cols_valid;
  logic               st_cols_ready;

  modport master (
    output ld_write, ld_sel, ld_addr, ld_data, start, abort, cfg_count, cfg_rep, cfg_instr,
    output st_instr_ready, st_rows_ready, st_cols_ready,
    input  busy, done, st_instr_data, st_instr_valid, st_rows_data, st_rows_valid,
    input  st_cols_data, st_cols_valid
  );

  modport slave (
    input  ld_write, ld_sel, ld_addr, ld_data, start, abort, cfg_count, cfg_rep, cfg_instr,
    input  st_instr_ready, st_rows_ready, st_cols_ready,
    output busy, done, st_instr_data, st_instr_valid, st_rows_data, st_rows_valid,
    output st_cols_data, st_cols_valid
  );
endinterface

// File: rtl/st_operand_feeder.sv
// Operand streamer: buffers row/col beats, issues one instruction word, then replays both buffers
// for the configured number of passes on independent Avalon-ST channels.
//
// state     | meaning
// ST_IDLE   | buffers writable, waiting for start
// ST_INSTR  | instruction word presented on st_instr
// ST_STREAM | rows/cols beats playing out; rearm cycle separates passes
module st_operand_feeder #(
  parameter int LANES   = 32,
  parameter int ELEM_W  = 8,
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 32,
  parameter int REP_W   = 8
) (
  input logic              clock_sink,
  input logic              reset_sink_reset_n,
  st_operand_feeder_if.slave bus
);
  localparam int DW = LANES * ELEM_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INSTR  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]         state;
  logic [INSTR_W-1:0] instr_q;
  logic [CW-1:0]      count_q;
  logic [REP_W-1:0]   rep_q;
  logic [REP_W-1:0]   pass_q;
  logic [AW-1:0]      ridx;
  logic [AW-1:0]      cidx;
  logic               rdone;
  logic               cdone;
  logic               rearm;
  logic               done_q;

  logic [DW-1:0] row_buf [DEPTH];
  logic [DW-1:0] col_buf [DEPTH];

  logic instr_hs, rows_hs, cols_hs;
  logic rows_last, cols_last, rows_fin, cols_fin;

  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.st_instr_data  = instr_q;
  assign bus.st_instr_valid = (state == ST_INSTR);
  assign bus.st_rows_valid  = (state == ST_STREAM) && !rdone;
  assign bus.st_cols_valid  = (state == ST_STREAM) && !cdone;
  assign bus.st_rows_data   = row_buf[ridx];
  assign bus.st_cols_data   = col_buf[cidx];

  assign instr_hs  = bus.st_instr_valid && bus.st_instr_ready;
  assign rows_hs   = bus.st_rows_valid && bus.st_rows_ready;
  assign cols_hs   = bus.st_cols_valid && bus.st_cols_ready;
  assign rows_last = (CW'(ridx) == count_q - CW'(1));
  assign cols_last = (CW'(cidx) == count_q - CW'(1));
  // A channel counts as finished in the same cycle its final beat is accepted.
  assign rows_fin  = rdone || (rows_hs && rows_last);
  assign cols_fin  = cdone || (cols_hs && cols_last);

  always_ff @(posedge clock_sink) begin
    if (bus.ld_write && state == ST_IDLE) begin
      if (bus.ld_sel) col_buf[bus.ld_addr] <= bus.ld_data;
      else            row_buf[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clock_sink or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state   <= ST_IDLE;
      instr_q <= '0;
      count_q <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      ridx    <= '0;
      cidx    <= '0;
      rdone   <= 1'b0;
      cdone   <= 1'b0;
      rearm   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= ST_IDLE;
        pass_q <= '0;
        ridx   <= '0;
        cidx   <= '0;
        rdone  <= 1'b0;
        cdone  <= 1'b0;
        rearm  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state   <= ST_INSTR;
              instr_q <= bus.cfg_instr;
              count_q <= (bus.cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : bus.cfg_count;
              rep_q   <= (bus.cfg_rep == '0) ? REP_W'(1) : bus.cfg_rep;
              pass_q  <= '0;
              ridx    <= '0;
              cidx    <= '0;
              rdone   <= 1'b0;
              cdone   <= 1'b0;
              rearm   <= 1'b0;
            end
          end
          ST_INSTR: begin
            if (instr_hs) begin
              if (count_q == '0) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else begin
                state <= ST_STREAM;
              end
            end
          end
          ST_STREAM: begin
            if (rearm) begin
              rdone <= 1'b0;
              cdone <= 1'b0;
              rearm <= 1'b0;
            end else begin
              if (rows_hs) begin
                if (rows_last) rdone <= 1'b1;
                else           ridx  <= ridx + AW'(1);
              end
              if (cols_hs) begin
                if (cols_last) cdone <= 1'b1;
                else           cidx  <= cidx + AW'(1);
              end
              // Flags stay set through the rearm cycle so both valids sit low for exactly one cycle.
              if (rows_fin && cols_fin) begin
                if (pass_q != rep_q - REP_W'(1)) begin
                  pass_q <= pass_q + REP_W'(1);
                  ridx   <= '0;
                  cidx   <= '0;
                  rdone  <= 1'b1;
                  cdone  <= 1'b1;
                  rearm  <= 1'b1;
                end else begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_st_operand_feeder.sv
// Directed bench for st_operand_feeder; a negedge monitor checks every beat against a scoreboard.
module tb_st_operand_feeder;
  localparam int LANES = 32, ELEM_W = 8, DEPTH = 32, INSTR_W = 32, REP_W = 8;
  localparam int DW = LANES * ELEM_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  st_operand_feeder_if #(.LANES(LANES), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W),
                         .REP_W(REP_W)) bus ();
  st_operand_feeder #(.LANES(LANES), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W),
                      .REP_W(REP_W)) dut (.clock_sink(clk), .reset_sink_reset_n(rst_n), .bus(bus));

  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_hs = -1;
  int rows_hs = 0, rows_last = -1, cols_last = -1, low_cyc = 0;
  logic [DW-1:0] rows_m [DEPTH];
  logic [DW-1:0] cols_m [DEPTH];
  logic [DW-1:0] row_q [$];
  logic [DW-1:0] col_q [$];
  logic [INSTR_W-1:0] instr_q [$];
  logic prev_rstall = 1'b0, prev_cstall = 1'b0;
  logic [DW-1:0] prev_rd, prev_cd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (prev_rstall && rst_n) begin
      chk("rows_hold_valid", DW'(bus.st_rows_valid), 1);
      chk("rows_hold_data", bus.st_rows_data, prev_rd);
    end
    if (prev_cstall && rst_n) begin
      chk("cols_hold_valid", DW'(bus.st_cols_valid), 1);
      chk("cols_hold_data", bus.st_cols_data, prev_cd);
    end
    prev_rstall = bus.st_rows_valid && !bus.st_rows_ready;
    prev_cstall = bus.st_cols_valid && !bus.st_cols_ready;
    prev_rd = bus.st_rows_data;
    prev_cd = bus.st_cols_data;
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.busy && !bus.st_instr_valid && !bus.st_rows_valid && !bus.st_cols_valid) low_cyc++;
    if (bus.st_instr_valid && bus.st_instr_ready) begin
      chk("instr_expected", DW'(instr_q.size() > 0), 1);
      if (instr_q.size() > 0) chk("instr_data", DW'(bus.st_instr_data), DW'(instr_q.pop_front()));
      last_hs = cyc;
    end
    if (bus.st_rows_valid && bus.st_rows_ready) begin
      chk("rows_expected", DW'(row_q.size() > 0), 1);
      if (row_q.size() > 0) chk("rows_data", bus.st_rows_data, row_q.pop_front());
      rows_hs++; rows_last = cyc; last_hs = cyc;
    end
    if (bus.st_cols_valid && bus.st_cols_ready) begin
      chk("cols_expected", DW'(col_q.size() > 0), 1);
      if (col_q.size() > 0) chk("cols_data", bus.st_cols_data, col_q.pop_front());
      cols_last = cyc; last_hs = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic sel, input int a, input logic [DW-1:0] d);
    bus.ld_write = 1'b1; bus.ld_sel = sel; bus.ld_addr = AW'(a); bus.ld_data = d;
    tick();
    bus.ld_write = 1'b0;
    if (sel) cols_m[a] = d; else rows_m[a] = d;
  endtask

  task automatic go(input int cnt, input int rep, input logic [INSTR_W-1:0] ins);
    int n = (cnt > DEPTH) ? DEPTH : cnt;
    int r = (rep == 0) ? 1 : rep;
    instr_q.push_back(ins);
    for (int p = 0; p < r; p++)
      for (int i = 0; i < n; i++) begin
        row_q.push_back(rows_m[i]);
        col_q.push_back(cols_m[i]);
      end
    bus.cfg_count = CW'(cnt); bus.cfg_rep = REP_W'(rep); bus.cfg_instr = ins; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit toggle_cols);
    int d0 = done_cnt;
    for (int k = 0; k < 600 && done_cnt == d0; k++) begin
      if (toggle_cols) bus.st_cols_ready = (k % 3 == 0);
      tick();
    end
    bus.st_cols_ready = 1'b1;
    chk({tag, "_done_once"}, DW'(done_cnt - d0), 1);
    chk({tag, "_done_after_last"}, DW'(done_cyc), DW'(last_hs + 1));
    chk({tag, "_rows_left"}, DW'(row_q.size()), 0);
    chk({tag, "_cols_left"}, DW'(col_q.size()), 0);
    chk({tag, "_busy_low"}, DW'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [DW-1:0] d;
    int base, d0, low0;
    bus.ld_write = 0; bus.ld_sel = 0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 0; bus.abort = 0; bus.cfg_count = '0; bus.cfg_rep = '0; bus.cfg_instr = '0;
    bus.st_instr_ready = 1; bus.st_rows_ready = 1; bus.st_cols_ready = 1;
    #12;
    chk("rst_busy", DW'(bus.busy), 0);
    chk("rst_done", DW'(bus.done), 0);
    chk("rst_valids", DW'({bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid}), 0);
    chk("rst_instr_data", DW'(bus.st_instr_data), 0);
    rst_n = 1'b1;
    tick();

    // 1: full 32-beat pass, all readies high
    for (int i = 0; i < DEPTH; i++) begin
      load(1'b0, i, {LANES{8'h01}});
      d = '0; d[i*ELEM_W +: ELEM_W] = 8'h01;
      load(1'b1, i, d);
    end
    go(32, 1, 32'h0002_0020);
    chk("t1_instr_valid", DW'(bus.st_instr_valid), 1);
    chk("t1_rows_not_before_instr", DW'(bus.st_rows_valid), 0);
    chk("t1_instr_word", DW'(bus.st_instr_data), DW'(32'h0002_0020));
    wait_done("t1", 1'b0);

    // 2: cols stalled 2 of 3 cycles
    go(32, 1, 32'h0002_0020);
    wait_done("t2", 1'b1);
    chk("t2_rows_finish_first", DW'(rows_last < cols_last), 1);

    // 3: count=4 rep=3 with distinct row data
    for (int i = 0; i < DEPTH; i++) load(1'b0, i, {LANES{8'(i + 16)}});
    low0 = low_cyc;
    go(4, 3, 32'hA5A5_0004);
    wait_done("t3", 1'b0);
    chk("t3_gap_cycles", DW'(low_cyc - low0), 2);

    // 4: count=0; load and start while busy must be ignored
    bus.st_instr_ready = 1'b0;
    go(0, 5, 32'h0000_0BAD);
    chk("t4_busy", DW'(bus.busy), 1);
    bus.ld_write = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = '0; bus.ld_data = '1;
    bus.start = 1'b1; bus.cfg_count = CW'(32); bus.cfg_instr = 32'h1234_5678;
    tick();
    bus.ld_write = 1'b0; bus.start = 1'b0;
    tick(2);
    chk("t4_instr_held", DW'(bus.st_instr_data), DW'(32'h0000_0BAD));
    bus.st_instr_ready = 1'b1;
    wait_done("t4", 1'b0);
    tick(3);
    chk("t4_no_restart", DW'(bus.busy), 0);

    // 5: abort after 10 row beats, then abort beats start, then full replay
    base = rows_hs;
    go(32, 1, 32'h0000_0005);
    for (int k = 0; k < 200 && rows_hs < base + 10; k++) tick();
    chk("t5_reached_10", DW'(rows_hs >= base + 10), 1);
    d0 = done_cnt;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_valids_low", DW'({bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid}), 0);
    chk("t5_busy_low", DW'(bus.busy), 0);
    row_q.delete(); col_q.delete(); instr_q.delete();
    tick(3);
    chk("t5_no_done", DW'(done_cnt - d0), 0);
    bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("t5_abort_beats_start", DW'(bus.busy), 0);
    go(32, 1, 32'h0000_0055);
    wait_done("t5", 1'b0);

    // 6: async reset mid-stream; buffers survive
    base = rows_hs;
    go(32, 2, 32'h0000_0006);
    for (int k = 0; k < 200 && rows_hs < base + 5; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valids_async", DW'({bus.st_instr_valid, bus.st_rows_valid, bus.st_cols_valid}), 0);
    chk("t6_busy_async", DW'(bus.busy), 0);
    chk("t6_instr_cleared", DW'(bus.st_instr_data), 0);
    row_q.delete(); col_q.delete(); instr_q.delete();
    #2 rst_n = 1'b1;
    tick();
    go(32, 1, 32'h0000_0066);
    wait_done("t6", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
